// File: rtl/hjcounter_pkg.sv
// Shared types and widths for hjcounter and its monitor.
// State encoding, default count width and status-counter widths live here.
package hjcounter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2
   } mon_state_t;

   localparam int DEF_WIDTH  = 7;
   localparam int ERR_CNT_W  = 8;
   localparam int WRAP_CNT_W = 8;
   localparam int RUN_W      = 4;

endpackage

// File: rtl/hjcounter_predict.sv
// Combinational modular next-value predictor: exp = (ref_val + STEP) mod (MAX + 1).
// The sum is kept one bit wider than the count so the compare sees the untruncated result.
module hjcounter_predict #(
   parameter int WIDTH = 7,
   parameter int STEP  = 1,
   parameter int MAX   = 127
) (
   input  logic [WIDTH-1:0] ref_val,
   output logic [WIDTH:0]   exp_val
);

   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MAX + 1);

   logic [WIDTH:0] sum;

   always_comb begin
      sum     = {1'b0, ref_val} + STEP_W;
      exp_val = (sum > MAX_W) ? (sum - MOD_W) : sum;
   end

endmodule

// File: rtl/hjcounter_monitor.sv
// Passive checker for the hjcounter cnt/cnt2 streams: predicts each sample from the
// previous one, flags mismatches, tracks lock and counts primary-counter wraps.
module hjcounter_monitor
   import hjcounter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP1  = 1,
   parameter int STEP2  = 2,
   parameter int MAX1   = 127,
   parameter int MAX2   = 127,
   parameter int LOCK_N = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  chk_en,
   input  logic                  clr,
   input  logic [WIDTH-1:0]      cnt,
   input  logic [WIDTH-1:0]      cnt2,
   output logic                  locked,
   output logic                  err_pulse,
   output logic                  sticky_err,
   output logic [ERR_CNT_W-1:0]  err_cnt,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
);

   localparam logic [RUN_W-1:0]     LOCK_V  = RUN_W'(LOCK_N);
   localparam logic [WIDTH-1:0]     MAX1_V  = WIDTH'(MAX1);
   localparam logic [ERR_CNT_W-1:0] ERR_SAT = '1;

   mon_state_t             state_reg, state_next;
   logic [WIDTH-1:0]       sample1_reg, sample2_reg;
   logic [WIDTH-1:0]       ref1_reg, ref1_next, ref2_reg, ref2_next;
   logic [RUN_W-1:0]       run_reg, run_next;
   logic                   locked_reg, locked_next;
   logic                   err_pulse_reg, err_pulse_next;
   logic                   sticky_reg, sticky_next;
   logic [ERR_CNT_W-1:0]   err_cnt_reg, err_cnt_next;
   logic [WRAP_CNT_W-1:0]  wrap_cnt_reg, wrap_cnt_next;
   logic [WIDTH:0]         exp1, exp2;
   logic                   match;

   hjcounter_predict #(.WIDTH(WIDTH), .STEP(STEP1), .MAX(MAX1)) u_pred1 (
      .ref_val (ref1_reg),
      .exp_val (exp1)
   );

   hjcounter_predict #(.WIDTH(WIDTH), .STEP(STEP2), .MAX(MAX2)) u_pred2 (
      .ref_val (ref2_reg),
      .exp_val (exp2)
   );

   assign match = ({1'b0, sample1_reg} == exp1) && ({1'b0, sample2_reg} == exp2);

   always_comb begin
      state_next     = state_reg;
      ref1_next      = ref1_reg;
      ref2_next      = ref2_reg;
      run_next       = run_reg;
      locked_next    = locked_reg;
      err_pulse_next = 1'b0;
      sticky_next    = sticky_reg;
      err_cnt_next   = err_cnt_reg;
      wrap_cnt_next  = wrap_cnt_reg;

      if (!chk_en) begin
         state_next  = IDLE;
         run_next    = '0;
         locked_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: state_next = ACQ;
            ACQ: begin
               ref1_next  = sample1_reg;
               ref2_next  = sample2_reg;
               state_next = TRACK;
            end
            TRACK: begin
               // Always resync to what was observed, good or bad.
               ref1_next = sample1_reg;
               ref2_next = sample2_reg;
               if (match) begin
                  run_next    = (run_reg >= LOCK_V) ? LOCK_V : run_reg + 1'b1;
                  locked_next = (run_next == LOCK_V);
                  if (locked_reg && ref1_reg == MAX1_V && sample1_reg == '0)
                     wrap_cnt_next = wrap_cnt_reg + 1'b1;
               end else begin
                  err_pulse_next = 1'b1;
                  sticky_next    = 1'b1;
                  run_next       = '0;
                  locked_next    = 1'b0;
                  if (err_cnt_reg != ERR_SAT)
                     err_cnt_next = err_cnt_reg + 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end

      // Clear wins over a coincident increment; err_pulse is left alone.
      if (clr) begin
         err_cnt_next  = '0;
         wrap_cnt_next = '0;
         sticky_next   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         sample1_reg   <= '0;
         sample2_reg   <= '0;
         ref1_reg      <= '0;
         ref2_reg      <= '0;
         run_reg       <= '0;
         locked_reg    <= 1'b0;
         err_pulse_reg <= 1'b0;
         sticky_reg    <= 1'b0;
         err_cnt_reg   <= '0;
         wrap_cnt_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         sample1_reg   <= cnt;
         sample2_reg   <= cnt2;
         ref1_reg      <= ref1_next;
         ref2_reg      <= ref2_next;
         run_reg       <= run_next;
         locked_reg    <= locked_next;
         err_pulse_reg <= err_pulse_next;
         sticky_reg    <= sticky_next;
         err_cnt_reg   <= err_cnt_next;
         wrap_cnt_reg  <= wrap_cnt_next;
      end
   end

   assign locked     = locked_reg;
   assign err_pulse  = err_pulse_reg;
   assign sticky_err = sticky_reg;
   assign err_cnt    = err_cnt_reg;
   assign wrap_cnt   = wrap_cnt_reg;

endmodule

// File: tb/tb_hjcounter_monitor.sv
// Directed bench for hjcounter_monitor: lock-up, wrap counting, error injection,
// saturation/clear, enable toggling and asynchronous reset.
module tb_hjcounter_monitor;

   logic       clk = 1'b0;
   logic       rst_n, chk_en, clr;
   logic [6:0] cnt, cnt2;
   logic       locked, err_pulse, sticky_err;
   logic [7:0] err_cnt, wrap_cnt;

   int checks   = 0;
   int failures = 0;

   hjcounter_monitor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .chk_en     (chk_en),
      .clr        (clr),
      .cnt        (cnt),
      .cnt2       (cnt2),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .sticky_err (sticky_err),
      .err_cnt    (err_cnt),
      .wrap_cnt   (wrap_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample, let it be captured, sample outputs 1 time unit later.
   task automatic drive(input int a, input int b);
      cnt  = 7'(a);
      cnt2 = 7'(b);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; chk_en = 1'b0; clr = 1'b0; cnt = '0; cnt2 = '0;
      tick();
      tick();
      check("rst_locked",    32'(locked),     0);
      check("rst_err_pulse", 32'(err_pulse),  0);
      check("rst_sticky",    32'(sticky_err), 0);
      check("rst_err_cnt",   32'(err_cnt),    0);
      check("rst_wrap_cnt",  32'(wrap_cnt),   0);

      // Clean count-up, through the cnt2 wraps and one cnt wrap.
      rst_n  = 1'b1;
      chk_en = 1'b1;
      for (int i = 0; i <= 168; i++) begin
         drive(i % 128, (2 * i) % 128);
         check("seq_locked",    32'(locked),    (i >= 5)   ? 1 : 0);
         check("seq_err_pulse", 32'(err_pulse), 0);
         check("seq_wrap_cnt",  32'(wrap_cnt),  (i >= 129) ? 1 : 0);
      end
      check("seq_err_cnt", 32'(err_cnt),    0);
      check("seq_sticky",  32'(sticky_err), 0);

      // Inject 50 where 41 is expected, then resume from 51.
      drive(50, 82);
      check("inj_pre_pulse", 32'(err_pulse), 0);
      drive(51, 84);
      check("inj_pulse",   32'(err_pulse),  1);
      check("inj_sticky",  32'(sticky_err), 1);
      check("inj_err_cnt", 32'(err_cnt),    1);
      check("inj_locked",  32'(locked),     0);
      drive(52, 86);
      check("inj_pulse_off", 32'(err_pulse),  0);
      check("inj_sticky_hd", 32'(sticky_err), 1);
      drive(53, 88);
      drive(54, 90);
      check("relock_early", 32'(locked), 0);
      drive(55, 92);
      check("relock",       32'(locked),   1);
      check("relock_errs",  32'(err_cnt),  1);
      check("relock_wraps", 32'(wrap_cnt), 1);

      // One cycle of chk_en low, then re-enable on a discontinuous value.
      chk_en = 1'b0;
      drive(56, 94);
      check("dis_locked", 32'(locked),    0);
      check("dis_pulse",  32'(err_pulse), 0);
      chk_en = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         drive(90 + k, 10 + 2 * k);
         check("reen_pulse",  32'(err_pulse), 0);
         check("reen_locked", 32'(locked),    (k == 5) ? 1 : 0);
      end
      check("reen_err_cnt", 32'(err_cnt), 1);

      // Stalled stream: every sample after the first mismatches.
      for (int k = 1; k <= 300; k++) begin
         drive(5, 5);
         check("sat_pulse",   32'(err_pulse), (k >= 2) ? 1 : 0);
         check("sat_err_cnt", 32'(err_cnt),   (k < 255) ? k : 255);
      end
      check("sat_sticky", 32'(sticky_err), 1);

      clr = 1'b1;
      drive(5, 5);
      check("clr_err_cnt",  32'(err_cnt),    0);
      check("clr_sticky",   32'(sticky_err), 0);
      check("clr_wrap_cnt", 32'(wrap_cnt),   0);
      check("clr_pulse",    32'(err_pulse),  1);
      clr = 1'b0;
      drive(5, 5);
      check("post_clr_err_cnt", 32'(err_cnt),    1);
      check("post_clr_sticky",  32'(sticky_err), 1);

      // Asynchronous reset between clock edges.
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_locked",   32'(locked),     0);
      check("arst_pulse",    32'(err_pulse),  0);
      check("arst_sticky",   32'(sticky_err), 0);
      check("arst_err_cnt",  32'(err_cnt),    0);
      check("arst_wrap_cnt", 32'(wrap_cnt),   0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         drive(i, 2 * i);
         check("rerun_locked", 32'(locked),    (i >= 5) ? 1 : 0);
         check("rerun_pulse",  32'(err_pulse), 0);
      end
      check("rerun_err_cnt", 32'(err_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hjcounter_monitor.md
Name: hjcounter_monitor

Overview:
Passive checker that sits beside hjcounter and consumes its two 7-bit count streams (cnt, cnt2) every clock. It predicts each next value from the previous sample, flags mismatches, tracks lock status and counts wrap-arounds. It is the consumer end of the counter interface, for bench and on-chip self-check use.

Parameters:
WIDTH, 7, width of both count inputs
STEP1, 1, expected per-cycle increment of cnt
STEP2, 2, expected per-cycle increment of cnt2
MAX1, 127, last value of cnt before it wraps to 0
MAX2, 127, last value of cnt2 before it wraps to 0
LOCK_N, 4, consecutive good checks required to assert locked (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
chk_en  in  1  checking enabled; 0 forces IDLE
clr  in  1  synchronous clear of err_cnt, wrap_cnt, sticky_err
cnt  in  WIDTH  observed primary count
cnt2  in  WIDTH  observed secondary count
locked  out  1  LOCK_N consecutive samples matched prediction
err_pulse  out  1  one-cycle pulse per mismatching sample
sticky_err  out  1  set on any mismatch, held until clr or reset
err_cnt  out  8  mismatch count, saturates at 255
wrap_cnt  out  8  wraps of cnt (MAX1 -> 0) seen while locked, modulo 256

Behaviour:
- Reset (rst_n=0, async): state IDLE; locked=0, err_pulse=0, sticky_err=0, err_cnt=0, wrap_cnt=0; ref registers=0; good-run counter=0.
- States: IDLE, ACQ, TRACK.
- IDLE: no checks. chk_en=1 -> ACQ.
- ACQ: capture cnt/cnt2 as reference, no compare; -> TRACK next cycle.
- TRACK, per cycle: exp1 = (ref1+STEP1) > MAX1 ? (ref1+STEP1)-(MAX1+1) : ref1+STEP1; same for exp2 with STEP2/MAX2. Sums are computed WIDTH+1 bits wide, with no truncation before compare.
- Match: cnt==exp1 and cnt2==exp2. Good-run counter increments, saturating at LOCK_N. locked=1 once it reaches LOCK_N.
- Mismatch, on either stream: err_pulse=1 for exactly one cycle, sticky_err=1, err_cnt+1 (saturating), good-run counter=0, locked=0. State stays TRACK.
- In all TRACK cycles, the current sample becomes the new reference, so the checker resyncs to the observed sequence.
- Wrap detection: a cycle with locked=1 and a matching sample where ref1==MAX1 and cnt==0 increments wrap_cnt.
- Latency: all outputs registered. The response to a sample taken at edge N is visible after edge N+1.
- chk_en deassert, any state -> IDLE next edge; locked=0, good-run counter=0. Error and wrap counters hold.
- Re-enable always passes through ACQ, so the first sample after enable is never checked.
- clr has priority over a simultaneous increment: counters become 0 and sticky_err=0, and the coincident error is dropped. err_pulse still fires.
- Reset mid-TRACK: everything returns to reset values immediately. The next enable re-acquires.
- STEP values of 0 are legal and mean a stalled counter is expected.

Decomposition:
- Shared package hjcounter_pkg: state enum (IDLE/ACQ/TRACK), default WIDTH, and counter-width constants shared with hjcounter.
- One sub-module, hjcounter_predict: combinational modular next-value predictor (ref, STEP, MAX -> exp), instantiated twice.
- FSM, counters and flags live in the top module.

Test Plan:
- Reset then chk_en=1; drive cnt=0,1,2,...; cnt2=0,2,4,... -> locked=1 after sample 5 (1 acquire + 4 good checks); err_pulse never asserts; err_cnt=0.
- Locked stream; drive cnt 125,126,127,0,1 -> no error; wrap_cnt increments 0->1 one cycle after the 0 sample.
- Locked stream; inject cnt=50 where 41 expected -> err_pulse high exactly one cycle; sticky_err=1; err_cnt=1; locked=0. Continue 51,52,53,54 -> locked=1 again.
- Force 300 consecutive mismatches (e.g. cnt constant 5) -> err_cnt saturates at 255; err_pulse every cycle after ACQ. Then clr=1 -> err_cnt=0, sticky_err=0.
- Toggle chk_en low one cycle mid-stream, then high with a discontinuous value (e.g. 90) -> state goes IDLE, then ACQ accepts 90; no error; locked after 4 more good samples.
- Assert rst_n=0 asynchronously mid-TRACK, between edges -> all outputs 0 immediately; after release, behaviour matches the first scenario.
